// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the memory-access pipeline stage:
//   - state_e   : stage FSM states (IDLE, ACCESS)
//   - DATA_W    : datapath / memory word width
//   - REG_IDX_W : register-file index width
//   - wb_en()   : writes to register 0 are never reported to writeback
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package mem_access_stage_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Register 0 is hard-wired, so a result destined for it produces no pulse.
  function automatic logic wb_en(input logic [REG_IDX_W-1:0] r);
    return (r != '0);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Bundles the execute->mem request, the mem->writeback result and the status
// flags of the memory-access stage.
//   master : execute-side / testbench view (drives the request)
//   slave  : the stage itself (drives ready, writeback and status)
// Signals:
//   in_valid, in_ready           request handshake
//   alu_result, store_data, rd   operands (alu_result is the byte address)
//   is_load, is_store            operation kind (both set = store)
//   wb_valid, wb_addr, wb_data   one-cycle writeback pulse and its payload
//   busy, align_err              status
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    alu_result;
  logic [DATA_W-1:0]    store_data;
  logic [REG_IDX_W-1:0] rd;
  logic                 is_load;
  logic                 is_store;
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_addr;
  logic [DATA_W-1:0]    wb_data;
  logic                 busy;
  logic                 align_err;

  modport master (
    output in_valid, alu_result, store_data, rd, is_load, is_store,
    input  in_ready, wb_valid, wb_addr, wb_data, busy, align_err
  );

  modport slave (
    input  in_valid, alu_result, store_data, rd, is_load, is_store,
    output in_ready, wb_valid, wb_addr, wb_data, busy, align_err
  );

endinterface

// File: rtl/mem_access_stage_dmem_sp.sv
// -----------------------------------------------------------------------------
// dmem_sp
// Single-port data memory: synchronous write, combinational read, one shared
// word address for both. Contents are never reset.
// Parameters: DEPTH (words, power of two), AW (address width).
// Ports:
//   clk   write clock
//   we    write enable, sampled on the rising edge
//   addr  word address
//   wdata write data
//   rdata read data for addr (combinational)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dmem_sp
  import mem_access_stage_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access pipeline stage. ALU ops pass straight to writeback one cycle
// after acceptance; loads/stores occupy the stage for MEM_LAT cycles (ACCESS)
// and then complete against the dmem_sp data memory.
// Parameters:
//   DEPTH   number of 32-bit data words (power of two, 2..256)
//   MEM_LAT access latency in cycles (1..15)
// Ports:
//   clk    stage clock (rising edge)
//   rst_n  asynchronous active-low reset
//   bus    mem_access_stage_if.slave (request, writeback and status)
// Optional feature:
//   MEM_ACCESS_ALIGN_CHK_EN  when defined, loads/stores with alu_result[1:0]
//                            != 0 are dropped and flagged with align_err;
//                            otherwise the low address bits are ignored and
//                            align_err is tied to 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_stage_if.slave  bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e               state_q,     state_d;
  logic [3:0]           cnt_q,       cnt_d;
  logic [IDX_W-1:0]     idx_q,       idx_d;
  logic [DATA_W-1:0]    sdata_q,     sdata_d;
  logic [REG_IDX_W-1:0] rd_q,        rd_d;
  logic                 st_q,        st_d;
  logic                 wb_valid_q,  wb_valid_d;
  logic [REG_IDX_W-1:0] wb_addr_q,   wb_addr_d;
  logic [DATA_W-1:0]    wb_data_q,   wb_data_d;

  logic                 accept;
  logic                 mem_op;
  logic                 align_fault;
  logic                 done;
  logic                 mem_we;
  logic [DATA_W-1:0]    mem_rdata;

  assign accept = bus.in_valid && (state_q == IDLE);
  // Both flags set is handled as a store; a load needs only is_load.
  assign mem_op = bus.is_load || bus.is_store;
  assign done   = (state_q == ACCESS) && (cnt_q == 4'd0);
  // The write lands on the completion edge, so an aborted access never writes.
  assign mem_we = done && st_q;

`ifdef MEM_ACCESS_ALIGN_CHK_EN
  logic align_err_q, align_err_d;
  assign align_fault = (bus.alu_result[1:0] != 2'b00);
  assign align_err_d = accept && mem_op && align_fault;
  assign bus.align_err = align_err_q;
`else
  assign align_fault   = 1'b0;
  assign bus.align_err = 1'b0;
`endif

  dmem_sp #(
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (sdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sdata_d    = sdata_q;
    rd_d       = rd_q;
    st_d       = st_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!mem_op) begin
            wb_valid_d = wb_en(bus.rd);
            wb_addr_d  = bus.rd;
            wb_data_d  = bus.alu_result;
          end else if (!align_fault) begin
            // Upper address bits are dropped: addresses wrap modulo DEPTH words.
            idx_d   = bus.alu_result[IDX_W+1:2];
            sdata_d = bus.store_data;
            rd_d    = bus.rd;
            st_d    = bus.is_store;
            cnt_d   = CNT_INIT;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          if (!st_q) begin
            wb_valid_d = wb_en(rd_q);
            wb_addr_d  = rd_q;
            wb_data_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      sdata_q     <= '0;
      rd_q        <= '0;
      st_q        <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
      align_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sdata_q     <= sdata_d;
      rd_q        <= rd_d;
      st_q        <= st_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
`ifdef MEM_ACCESS_ALIGN_CHK_EN
      align_err_q <= align_err_d;
`endif
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q == ACCESS);
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;

endmodule
